sum5_seq: RTL and testbench

SUM5_SEQ -- requirements
Module: sum5_seq

---
 rtl/sum5_seq.sv | 108 ++++++++++
 tb/tb_sum5_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sum5_seq.sv
// Sequential 5-source accumulator: walks the enabled mux selects in ascending order and sums
// the mux data into a registered total with a sticky carry-out flag.
module sum5_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       src_mask,
  input  logic [WIDTH-1:0] mux_out,
  output logic [2:0]       select,
  output logic [WIDTH-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e           state_q, state_d;
  logic [4:0]       mask_q, mask_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   add_full;
  logic             first_found, next_found;
  logic [2:0]       first_idx, next_idx;

  assign add_full = {1'b0, sum_q} + {1'b0, mux_out};

  // Descending scans so the last hit is the lowest qualifying index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = 3'd0;
    next_found  = 1'b0;
    next_idx    = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (src_mask[i]) begin
        first_found = 1'b1;
        first_idx   = 3'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= 5'd0;
      sel_q   <= 3'd0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d = src_mask;
          sum_d  = '0;
          ovf_d  = 1'b0;
          if (first_found) begin
            sel_d   = first_idx;
            state_d = StAcc;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAcc: begin
        sum_d = add_full[WIDTH-1:0];
        if (add_full[WIDTH]) ovf_d = 1'b1;
        if (next_found) sel_d = next_idx;
        else            state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        sel_d   = 3'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q == StAcc);
    done     = (state_q == StDone);
    select   = sel_q;
    sum      = sum_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_sum5_seq.sv
// Directed, table-driven bench for sum5_seq with a behavioural 5-way source mux.
module tb_sum5_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  src_mask;
  logic [31:0] mux_out;
  logic [2:0]  select;
  logic [31:0] sum;
  logic        busy;
  logic        done;
  logic        overflow;

  logic [31:0] vals [5];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [4:0]  mask;
    logic [31:0] v0, v1, v2, v3, v4;
    logic [31:0] exp_sum;
    logic        exp_ovf;
    int          exp_cyc;   // cycle after start edge in which done is high
    int          exp_busy;
    logic [14:0] exp_seq;   // selects seen while busy, oldest in the upper bits
  } vec_t;

  vec_t vecs [6];

  sum5_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_mask (src_mask),
    .mux_out  (mux_out),
    .select   (select),
    .sum      (sum),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always_comb mux_out = (select <= 3'd4) ? vals[select] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; disturb injects a restart and mask change mid-pass.
  task automatic run_pass(input int idx, input bit disturb);
    int          cyc;
    int          busy_cnt;
    logic [14:0] seq;
    logic [31:0] held;
    vals[0] = vecs[idx].v0; vals[1] = vecs[idx].v1; vals[2] = vecs[idx].v2;
    vals[3] = vecs[idx].v3; vals[4] = vecs[idx].v4;
    src_mask = vecs[idx].mask;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    src_mask = 5'b01010;
    cyc      = 1;
    busy_cnt = 0;
    seq      = '0;
    while (!done && cyc < 20) begin
      if (cyc == 1 && busy) begin
        chk({vecs[idx].name, "_sum_cleared"}, sum, 32'd0);
        chk({vecs[idx].name, "_ovf_cleared"}, {31'd0, overflow}, 32'd0);
      end
      if (busy) begin
        busy_cnt++;
        seq = {seq[11:0], select};
        chk({vecs[idx].name, "_sel_range"}, {31'd0, select <= 3'd4}, 32'd1);
      end
      if (disturb && cyc == 2) begin
        start    = 1'b1;
        src_mask = 5'b00001;
      end
      if (disturb && cyc == 3) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({vecs[idx].name, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({vecs[idx].name, "_done_cycle"}, cyc, vecs[idx].exp_cyc);
    chk({vecs[idx].name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({vecs[idx].name, "_sum"}, sum, vecs[idx].exp_sum);
    chk({vecs[idx].name, "_ovf"}, {31'd0, overflow}, {31'd0, vecs[idx].exp_ovf});
    chk({vecs[idx].name, "_busy_cycles"}, busy_cnt, vecs[idx].exp_busy);
    chk({vecs[idx].name, "_sel_seq"}, {17'd0, seq}, {17'd0, vecs[idx].exp_seq});
    held = sum;
    @(negedge clk);
    chk({vecs[idx].name, "_done_pulse_end"}, {31'd0, done}, 32'd0);
    chk({vecs[idx].name, "_sel_idle"}, {29'd0, select}, 32'd0);
    chk({vecs[idx].name, "_sum_held"}, sum, held);
    repeat (2) begin
      @(negedge clk);
      chk({vecs[idx].name, "_no_extra_done"}, {30'd0, done, busy}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{"full",   5'b11111, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5,
                32'd15, 1'b0, 6, 5, 15'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4})};
    vecs[1] = '{"sparse", 5'b10100, 32'd99, 32'd99, 32'd10, 32'd99, 32'd7,
                32'd17, 1'b0, 3, 2, 15'({3'd2, 3'd4})};
    vecs[2] = '{"empty",  5'b00000, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9,
                32'd0, 1'b0, 1, 0, 15'd0};
    vecs[3] = '{"ovf",    5'b00011, 32'hFFFF_FFFF, 32'd2, 32'd9, 32'd9, 32'd9,
                32'd1, 1'b1, 3, 2, 15'({3'd0, 3'd1})};
    vecs[4] = '{"small",  5'b00011, 32'd3, 32'd4, 32'd9, 32'd9, 32'd9,
                32'd7, 1'b0, 3, 2, 15'({3'd0, 3'd1})};
    vecs[5] = '{"single", 5'b10000, 32'd9, 32'd9, 32'd9, 32'd9, 32'd5,
                32'd5, 1'b0, 2, 1, 15'd4};

    for (int i = 0; i < 5; i++) vals[i] = 32'd0;
    rst      = 1'b1;
    start    = 1'b0;
    src_mask = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {select, sum[27:0], busy, done, overflow}, 32'd0);
    chk("reset_sum", sum, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_pass(i, 1'b0);

    // Restart request and mask change mid-pass must be ignored.
    run_pass(0, 1'b1);

    // Reset while accumulating at select 2 aborts the pass.
    for (int i = 0; i < 5; i++) vals[i] = 32'(i + 1);
    src_mask = 5'b11111;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !(busy && select == 3'd2); i++) @(negedge clk);
    chk("midpass_reached_sel2", {31'd0, busy && select == 3'd2}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midpass_rst_outputs", {29'd0, select}, 32'd0);
    chk("midpass_rst_sum", sum, 32'd0);
    chk("midpass_rst_flags", {29'd0, busy, done, overflow}, 32'd0);
    run_pass(0, 1'b0);

    // Reset dominates a coincident start.
    rst      = 1'b1;
    start    = 1'b1;
    src_mask = 5'b11111;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_dom_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("rst_dom_no_pass", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    run_pass(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
